// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI3 responder that serves one transaction at a time and turns each burst
//   into word accesses on a synchronous single-port SRAM (1-cycle read latency).
//   Supports INCR, FIXED and WRAP bursts (burst type 11 behaves as INCR), byte
//   strobes, and round-robin arbitration between simultaneous AR and AW requests.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   ar*/arvalid/arready     read address channel (lock/cache/prot ignored)
//   r*/rvalid/rready        read data channel, rresp always OKAY
//   aw*/awvalid/awready     write address channel (lock/cache/prot ignored)
//   w*/wvalid/wready        write data channel (wid ignored)
//   b*/bvalid/bready        write response, SLVERR when wlast disagreed with len
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   SRAM port; ram_we == 0 is a read
//
// Address bits above MEM_AW+1 are dropped, so the SRAM aliases across the
// whole 32-bit space.
module axi_sram_slave #(
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              reset,
    // read address
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    // read data
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    // write address
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    // write data
    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    // write response
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    // SRAM
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_RESP = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t      state;
    logic        last_rd;     // last grant went to a read; breaks AR/AW ties
    logic        err;         // sticky wlast mismatch for the current write
    logic        rd_first;    // first cycle of RD_RESP: SRAM output is live
    logic [31:0] rdata_q;     // holds read data while the master stalls
    logic [3:0]  cur_id;
    logic [31:0] cur_addr;
    logic [7:0]  cur_len;
    logic [2:0]  cur_size;
    logic [1:0]  cur_burst;
    logic [7:0]  beat;

    logic        rd_grant;
    logic        wr_grant;
    logic        w_fire;
    logic        last_beat;
    logic [31:0] next_addr;

    logic        unused_ok;
    assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    // Next beat address. The WRAP mask is the burst footprint minus one, so the
    // low bits step through the container while the high bits stay put.
    function automatic logic [31:0] adv_addr(input logic [31:0] a,
                                             input logic [7:0]  len,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
        logic [31:0] sz;
        logic [31:0] mask;
        sz   = 32'd1 << size;
        mask = (({24'd0, len} + 32'd1) * sz) - 32'd1;
        case (burst)
            2'b00:   adv_addr = a;
            2'b10:   adv_addr = (a & ~mask) | ((a + sz) & mask);
            default: adv_addr = a + sz;
        endcase
    endfunction

    // Tie goes to the opposite of the previous grant.
    assign rd_grant  = arvalid && (!awvalid || !last_rd);
    assign wr_grant  = awvalid && (!arvalid ||  last_rd);

    assign last_beat = (beat == cur_len);
    assign next_addr = adv_addr(cur_addr, cur_len, cur_size, cur_burst);

    assign arready   = (state == IDLE) && rd_grant;
    assign awready   = (state == IDLE) && wr_grant;

    assign rvalid    = (state == RD_RESP);
    assign rid       = cur_id;
    assign rresp     = 2'b00;
    assign rlast     = rvalid && last_beat;
    assign rdata     = rd_first ? ram_rdata : rdata_q;

    assign wready    = (state == WR_DATA);
    assign w_fire    = wready && wvalid;

    assign bvalid    = (state == WR_RESP);
    assign bid       = cur_id;
    assign bresp     = (bvalid && err) ? 2'b10 : 2'b00;

    // Writes go straight through in the W handshake cycle.
    assign ram_en    = (state == RD_REQ) || w_fire;
    assign ram_we    = w_fire ? wstrb : 4'h0;
    assign ram_wdata = w_fire ? wdata : 32'h0;
    assign ram_addr  = cur_addr[MEM_AW+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_rd   <= 1'b0;
            err       <= 1'b0;
            rd_first  <= 1'b0;
            rdata_q   <= 32'h0;
            cur_id    <= 4'h0;
            cur_addr  <= 32'h0;
            cur_len   <= 8'h0;
            cur_size  <= 3'h0;
            cur_burst <= 2'h0;
            beat      <= 8'h0;
        end else begin
            rd_first <= 1'b0;
            if (rd_first)
                rdata_q <= ram_rdata;

            case (state)
                IDLE: begin
                    if (rd_grant) begin
                        cur_id    <= arid;
                        cur_addr  <= araddr;
                        cur_len   <= arlen;
                        cur_size  <= arsize;
                        cur_burst <= arburst;
                        beat      <= 8'h0;
                        last_rd   <= 1'b1;
                        state     <= RD_REQ;
                    end else if (wr_grant) begin
                        cur_id    <= awid;
                        cur_addr  <= awaddr;
                        cur_len   <= awlen;
                        cur_size  <= awsize;
                        cur_burst <= awburst;
                        beat      <= 8'h0;
                        last_rd   <= 1'b0;
                        state     <= WR_DATA;
                    end
                end
                RD_REQ: begin
                    rd_first <= 1'b1;
                    state    <= RD_RESP;
                end
                RD_RESP: begin
                    if (rready) begin
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            beat     <= beat + 8'd1;
                            cur_addr <= next_addr;
                            state    <= RD_REQ;
                        end
                    end
                end
                WR_DATA: begin
                    if (wvalid) begin
                        if (wlast != last_beat)
                            err <= 1'b1;
                        // beat count, not wlast, ends the burst
                        if (last_beat) begin
                            state <= WR_RESP;
                        end else begin
                            beat     <= beat + 8'd1;
                            cur_addr <= next_addr;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 slave (responder) that serves the CPU-side AXI master traffic produced by the crossbar, one transaction at a time, and turns each burst into word accesses on a synchronous single-port SRAM. It sits at the memory end of the bus, behind the crossbar master port, in simulation and FPGA builds. It supports INCR, FIXED and WRAP bursts, byte strobes, and round-robin arbitration between reads and writes.

## Interface

Parameters:
- `MEM_AW`, default 14: SRAM word-address width, giving 2^MEM_AW 32-bit words.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `arid, araddr, arlen, arsize, arburst`  in  4/32/8/3/2  read address channel fields; latched on the AR handshake.
- `arlock, arcache, arprot, awlock, awcache, awprot`  in  2/4/3/2/4/3  ignored.
- `arvalid`  in  1  / `arready`  out  1: AR handshake.
- `rid, rdata, rresp, rlast`  out  4/32/2/1  read data channel.
- `rvalid`  out  1  / `rready`  in  1: R handshake.
- `awid, awaddr, awlen, awsize, awburst`  in  4/32/8/3/2  write address channel fields; latched on the AW handshake.
- `awvalid`  in  1  / `awready`  out  1: AW handshake.
- `wid, wdata, wstrb, wlast`  in  4/32/4/1  write data; `wid` is ignored.
- `wvalid`  in  1  / `wready`  out  1: W handshake.
- `bid, bresp`  out  4/2  write response.
- `bvalid`  out  1  / `bready`  in  1: B handshake.
- `ram_en`  out  1  SRAM access enable.
- `ram_we`  out  4  byte write enables. `ram_en` with `ram_we` of 0 is a read.
- `ram_addr`  out  MEM_AW  word address, taken from `cur_addr[MEM_AW+1:2]`.
- `ram_wdata`  out  32  SRAM write data.
- `ram_rdata`  in  32  SRAM read data, valid exactly one cycle after a read enable.

## Operation

States: IDLE, RD_REQ, RD_RESP, WR_DATA, WR_RESP.

IDLE
- `arready` = 1 only when a read is granted; `awready` = 1 only when a write is granted.
- A request is granted whenever its valid is high and the other valid is low.
- If both `arvalid` and `awvalid` are high, the grant goes to the opposite of the `last_rd` flag.
- `last_rd` resets to 0, so a read wins the first tie. It is updated on every grant.
- Handshake latches id, address (`cur_addr`), len, size and burst, and clears the beat counter `beat`.
- Next state: read → RD_REQ; write → WR_DATA.

RD_REQ
- `ram_en` = 1, `ram_we` = 0.
- Next state: RD_RESP.

RD_RESP
- `rvalid` = 1, `rid` = latched id, `rresp` = 2'b00, `rlast` = (`beat` == len).
- `rdata`: `ram_rdata` on the first RD_RESP cycle; after that, a register captured on that first cycle. Data stays stable while `rready` = 0.
- On `rvalid` & `rready`:
  - last beat → IDLE;
  - otherwise `beat`+1, advance address, → RD_REQ.
- Throughput is 2 cycles per beat.

WR_DATA
- `wready` = 1.
- On `wvalid`, in the same cycle: `ram_en` = 1, `ram_we` = `wstrb`, `ram_wdata` = `wdata`, `ram_addr` = current address. Then `beat`+1 and advance address.
- A sticky `err` flag is set if `wlast` ≠ (`beat` == len) on any beat.
- After beat len+1 is accepted (the count rules, not `wlast`) → WR_RESP.

WR_RESP
- `bvalid` = 1, `bid` = latched id, `bresp` = `err` ? 2'b10 (SLVERR) : 2'b00.
- On `bready` → IDLE; `err` clears.

Address advance (`sz` = 1<<size):
- FIXED (00): unchanged.
- INCR (01): `cur_addr` + `sz`, with a 32-bit wrap-around.
- WRAP (10): `mask` = ((len+1)·`sz`) − 1; next = (`cur_addr` & ~`mask`) | ((`cur_addr` + `sz`) & `mask`).
- Burst 11: treated as INCR.

Other rules:
- Address bits above MEM_AW+1 are ignored, so the SRAM aliases across the address space.
- Sub-word reads return the full word.
- Subword writes rely solely on `wstrb`.

## Timing

- Reset: state = IDLE, `last_rd` = 0, `err` = 0. All valid/ready outputs are 0 on the cycle after the reset edge (except a granted IDLE `arready`/`awready` after reset is released). `ram_en` = 0, `ram_we` = 0. `rid`, `rdata`, `rresp`, `rlast`, `bid`, `bresp`, `ram_addr` and `ram_wdata` reset to 0.
- Reset mid-burst abandons the transaction: no further R/B beats and no SRAM write after the reset cycle.
- `arready` and `awready` are combinational from state, valids and `last_rd`. They are never both 1.
- All other outputs are registered state or muxes of registered state, except `ram_*` during WR_DATA, which follow `wvalid`, `wdata` and `wstrb` combinationally.
- Read latency: AR handshake at cycle T → `ram_en` at T+1 → `rvalid` at T+2. Next beat `rvalid` at H+2, where H is the R handshake cycle.
- Write: AW handshake at T → `wready` at T+1. The last W handshake at W → `bvalid` at W+1.
- The B handshake at cycle B returns to IDLE, so a new AR/AW can be accepted at B+1. The same applies to the last R handshake.
- `arlen` = 0 gives a single beat; `arlen` = 255 gives 256 beats. `beat` is 8 bits and never wraps within a burst.

## Test plan

- Single read: preload word 0x100 = 0xDEADBEEF; AR addr 0x400, len 0 → `rvalid` 2 cycles later, `rdata` 0xDEADBEEF, `rlast` = 1, `rid` echoed.
- INCR write: len 3, size 2, addr 0x40, wstrb 4'b0011 on beat 2 → words 0x10–0x13 written; word 0x12 has only bytes 0–1 changed. `bresp` OKAY, `bvalid` 1 cycle after the 4th beat.
- WRAP read: len 3, size 2, addr 0x38 → word addresses 0x0E, 0x0F, 0x0C, 0x0D. With `rready` held low 3 cycles on beat 1, `rdata` stays stable.
- Simultaneous `arvalid`/`awvalid` repeated 3 times after reset → grant order read, write, read.
- wlast error: len 1 write with `wlast` asserted on beat 0 → 2 beats still accepted, `bresp` = 2'b10. The next write returns OKAY.
- Reset asserted during beat 2 of a len 7 read → `rvalid` 0 from the next cycle, state IDLE, `arready` returns when `arvalid` is reasserted.
